// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared stall-bus encodings, multi-cycle FSM state codes and stall-priority helpers
// for the pipeline stall/flush controller.
package pipe_stall_ctrl_pkg;

   localparam int STALL_BUS = 6;

   localparam logic STALL_ENABLE  = 1'b1;
   localparam logic STALL_DISABLE = 1'b0;

   // One bit per pipeline register: [0]=PC ... [5]=WB.
   localparam logic [STALL_BUS-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_BUS-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_BUS-1:0] STALL_EX   = 6'b001111;
   localparam logic [STALL_BUS-1:0] STALL_MEM  = 6'b011111;

   typedef enum logic {
      MC_IDLE = 1'b0,
      MC_BUSY = 1'b1
   } mc_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_ID   = 2'd1,
      CAUSE_EX   = 2'd2,
      CAUSE_MEM  = 2'd3
   } stall_cause_e;

   function automatic stall_cause_e pick_cause(input logic mem, input logic ex, input logic id);
      stall_cause_e c;
      if (mem)
         c = CAUSE_MEM;
      else if (ex)
         c = CAUSE_EX;
      else if (id)
         c = CAUSE_ID;
      else
         c = CAUSE_NONE;
      return c;
   endfunction

   function automatic logic [STALL_BUS-1:0] cause_vec(input stall_cause_e c);
      logic [STALL_BUS-1:0] v;
      case (c)
         CAUSE_MEM: v = STALL_MEM;
         CAUSE_EX:  v = STALL_EX;
         CAUSE_ID:  v = STALL_ID;
         default:   v = STALL_NONE;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages (master) and the stall controller (slave).
interface pipe_stall_ctrl_if #(
   parameter int MC_CNT_W = 5
);
   import pipe_stall_ctrl_pkg::*;

   logic                 id_stallreq;
   logic                 ex_mc_start;
   logic [MC_CNT_W-1:0]  ex_mc_cycles;
   logic                 mem_req;
   logic                 mem_ack;
   logic                 id_branch_flush;
   logic [STALL_BUS-1:0] ctrl_stall;
   logic                 ctrl_flush;
   logic                 ex_mc_done;
   logic                 mem_err;

   modport master (
      output id_stallreq, ex_mc_start, ex_mc_cycles, mem_req, mem_ack, id_branch_flush,
      input  ctrl_stall, ctrl_flush, ex_mc_done, mem_err
   );

   modport slave (
      input  id_stallreq, ex_mc_start, ex_mc_cycles, mem_req, mem_ack, id_branch_flush,
      output ctrl_stall, ctrl_flush, ex_mc_done, mem_err
   );

endinterface

// File: rtl/pipe_mc_seq.sv
// EX multi-cycle sequencer: N stall cycles then one done cycle; the countdown
// freezes while the MEM stage is stalling.
module pipe_mc_seq
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MC_CNT_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [MC_CNT_W-1:0] cycles,
   input  logic                mem_stall,
   output logic                ex_stall,
   output logic                ex_mc_done
);

   mc_state_e           state_reg, state_next;
   logic [MC_CNT_W-1:0] cnt_reg, cnt_next;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= MC_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      ex_stall   = STALL_DISABLE;
      ex_mc_done = 1'b0;
      case (state_reg)
         MC_IDLE: begin
            if (start) begin
               if (cycles == '0) begin
                  ex_mc_done = 1'b1;
               end else begin
                  // The issuing cycle is the first of the N stall cycles.
                  ex_stall   = STALL_ENABLE;
                  cnt_next   = cycles - MC_CNT_W'(1);
                  state_next = MC_BUSY;
               end
            end
         end
         MC_BUSY: begin
            if (cnt_reg != '0) begin
               ex_stall = STALL_ENABLE;
               if (!mem_stall)
                  cnt_next = cnt_reg - MC_CNT_W'(1);
            end else if (!mem_stall) begin
               ex_mc_done = 1'b1;
               state_next = MC_IDLE;
            end else begin
               // Result ready but MEM holds the pipe; keep the op parked in EX.
               ex_stall = STALL_ENABLE;
            end
         end
         default: begin
            state_next = MC_IDLE;
         end
      endcase
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller with MEM watchdog and EX multi-cycle sequencer.
// Define CTRL_PERF_EN to add saturating per-cause stall performance counters.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int MC_CNT_W    = 5,
   parameter int MEM_TIMEOUT = 255
`ifdef CTRL_PERF_EN
   ,
   parameter int PERF_W      = 32
`endif
) (
   input  logic              clk,
   input  logic              rst,
   pipe_stall_ctrl_if.slave  bus
`ifdef CTRL_PERF_EN
   ,
   output logic [PERF_W-1:0] perf_mem_stall,
   output logic [PERF_W-1:0] perf_ex_stall,
   output logic [PERF_W-1:0] perf_id_stall
`endif
);

   localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);

   logic [WCNT_W-1:0] wcnt_reg, wcnt_next;
   logic              mem_wait;
   logic              timeout_hit;
   logic              mem_stall;
   logic              ex_stall;
   logic              mc_done;
   stall_cause_e      cause;

   assign mem_wait    = bus.mem_req & ~bus.mem_ack;
   assign timeout_hit = mem_wait & (wcnt_reg == WCNT_W'(MEM_TIMEOUT));
   assign mem_stall   = mem_wait & ~timeout_hit;

   // Watchdog restarts on ack, on a dropped request, and right after it fires.
   always_comb begin
      wcnt_next = '0;
      if (mem_stall)
         wcnt_next = wcnt_reg + WCNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wcnt_reg <= '0;
      else
         wcnt_reg <= wcnt_next;
   end

   pipe_mc_seq #(
      .MC_CNT_W (MC_CNT_W)
   ) u_mc_seq (
      .clk        (clk),
      .rst        (rst),
      .start      (bus.ex_mc_start),
      .cycles     (bus.ex_mc_cycles),
      .mem_stall  (mem_stall),
      .ex_stall   (ex_stall),
      .ex_mc_done (mc_done)
   );

   assign cause          = pick_cause(mem_stall, ex_stall, bus.id_stallreq);
   assign bus.ctrl_stall = cause_vec(cause);
   assign bus.ctrl_flush = bus.id_branch_flush & (bus.ctrl_stall[1] == STALL_DISABLE);
   assign bus.ex_mc_done = mc_done;
   assign bus.mem_err    = timeout_hit;

`ifdef CTRL_PERF_EN
   logic [2:0]             perf_hit;
   logic [2:0][PERF_W-1:0] perf_cnt;

   // Only the winning cause is charged for a stalled cycle.
   assign perf_hit[0] = (cause == CAUSE_MEM);
   assign perf_hit[1] = (cause == CAUSE_EX);
   assign perf_hit[2] = (cause == CAUSE_ID);

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_perf
         logic [PERF_W-1:0] cnt_reg;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               cnt_reg <= '0;
            else if (perf_hit[gi] && (cnt_reg != '1))
               cnt_reg <= cnt_reg + PERF_W'(1);
         end
         assign perf_cnt[gi] = cnt_reg;
      end
   endgenerate

   assign perf_mem_stall = perf_cnt[0];
   assign perf_ex_stall  = perf_cnt[1];
   assign perf_id_stall  = perf_cnt[2];
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: a cycle-level behavioural model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_pipe_stall_ctrl;
   import pipe_stall_ctrl_pkg::*;

   localparam int MC_CNT_W    = 5;
   localparam int MEM_TIMEOUT = 255;
   localparam int PERF_W      = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pipe_stall_ctrl_if #(.MC_CNT_W(MC_CNT_W)) bus ();

`ifdef CTRL_PERF_EN
   logic [PERF_W-1:0] perf_mem_stall, perf_ex_stall, perf_id_stall;
`endif

   pipe_stall_ctrl #(
      .MC_CNT_W    (MC_CNT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
`ifdef CTRL_PERF_EN
      ,
      .PERF_W      (PERF_W)
`endif
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .bus            (bus)
`ifdef CTRL_PERF_EN
      ,
      .perf_mem_stall (perf_mem_stall),
      .perf_ex_stall  (perf_ex_stall),
      .perf_id_stall  (perf_id_stall)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Model state: op in flight, stall cycles still owed, cycles MEM has waited.
   bit  m_op;
   int  m_owed;
   int  m_wait;
   int  m_perf_mem, m_perf_ex, m_perf_id;

   logic [5:0] exp_stall;
   logic       exp_flush, exp_done, exp_err;
   logic       e_mem, e_ex, e_wait;

   always_comb begin
      exp_stall = 6'b000000;
      exp_flush = 1'b0;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      e_mem     = 1'b0;
      e_ex      = 1'b0;
      e_wait    = 1'b0;
      if (rst) begin
         e_wait  = bus.mem_req && !bus.mem_ack;
         e_mem   = e_wait && (m_wait < MEM_TIMEOUT);
         exp_err = e_wait && (m_wait == MEM_TIMEOUT);
         if (!m_op) begin
            if (bus.ex_mc_start) begin
               if (bus.ex_mc_cycles == 0)
                  exp_done = 1'b1;
               else
                  e_ex = 1'b1;
            end
         end else if (m_owed > 0) begin
            e_ex = 1'b1;
         end else if (!e_mem) begin
            exp_done = 1'b1;
         end
         if (e_mem)
            exp_stall = 6'b011111;
         else if (e_ex)
            exp_stall = 6'b001111;
         else if (bus.id_stallreq)
            exp_stall = 6'b000111;
         exp_flush = bus.id_branch_flush && !exp_stall[1];
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_op       <= 1'b0;
         m_owed     <= 0;
         m_wait     <= 0;
         m_perf_mem <= 0;
         m_perf_ex  <= 0;
         m_perf_id  <= 0;
      end else begin
         if (!m_op) begin
            if (bus.ex_mc_start && bus.ex_mc_cycles != 0) begin
               m_op   <= 1'b1;
               m_owed <= int'(bus.ex_mc_cycles) - 1;
            end
         end else if (!e_mem) begin
            if (m_owed > 0)
               m_owed <= m_owed - 1;
            else
               m_op <= 1'b0;
         end
         m_wait <= e_mem ? m_wait + 1 : 0;
         if (e_mem)
            m_perf_mem <= m_perf_mem + 1;
         else if (e_ex)
            m_perf_ex <= m_perf_ex + 1;
         else if (bus.id_stallreq)
            m_perf_id <= m_perf_id + 1;
      end
   end

   // Per-cycle comparison away from the active edge.
   always @(negedge clk) begin
      check("cycle_outputs", {58'd0, bus.ctrl_stall, bus.ctrl_flush, bus.ex_mc_done, bus.mem_err},
            {58'd0, exp_stall, exp_flush, exp_done, exp_err});
`ifdef CTRL_PERF_EN
      check("cycle_perf_mem", 64'(perf_mem_stall), 64'(m_perf_mem));
      check("cycle_perf_ex",  64'(perf_ex_stall),  64'(m_perf_ex));
      check("cycle_perf_id",  64'(perf_id_stall),  64'(m_perf_id));
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int lat;
      bus.id_stallreq     = 1'b0;
      bus.ex_mc_start     = 1'b0;
      bus.ex_mc_cycles    = '0;
      bus.mem_req         = 1'b0;
      bus.mem_ack         = 1'b0;
      bus.id_branch_flush = 1'b0;

      // Reset state
      #2;
      check("reset_outputs", {58'd0, bus.ctrl_stall, bus.ctrl_flush, bus.ex_mc_done, bus.mem_err}, 64'd0);
      step();
      rst = 1'b1;
      step();

      // Load-use stall for one cycle
      bus.id_stallreq = 1'b1;
      #1 check("id_stall", 64'(bus.ctrl_stall), 64'b000111);
      step();
      bus.id_stallreq = 1'b0;
      #1 check("id_release", 64'(bus.ctrl_stall), 64'b000000);

      // Multi-cycle op N=4
      step();
      bus.ex_mc_start  = 1'b1;
      bus.ex_mc_cycles = 5'd4;
      n   = 0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (bus.ex_mc_done) begin
            lat = k;
            break;
         end
         if (bus.ctrl_stall == 6'b001111)
            n++;
         step();
      end
      check("ex4_stall_cycles", 64'(n), 64'd4);
      check("ex4_done_latency", 64'(lat), 64'd4);
      check("ex4_done_vec", 64'(bus.ctrl_stall), 64'd0);
      bus.ex_mc_start = 1'b0;

      // Multi-cycle op N=0: done at once
      step();
      bus.ex_mc_start  = 1'b1;
      bus.ex_mc_cycles = 5'd0;
      #1 check("ex0_done", 64'(bus.ex_mc_done), 64'd1);
      check("ex0_no_stall", 64'(bus.ctrl_stall), 64'd0);
      step();
      bus.ex_mc_start = 1'b0;
      #1 check("ex0_done_drop", 64'(bus.ex_mc_done), 64'd0);

      // Memory stall over an N=4 op: counter freezes for 3 cycles
      step();
      bus.ex_mc_start  = 1'b1;
      bus.ex_mc_cycles = 5'd4;
      #1 check("mx_t0", 64'(bus.ctrl_stall), 64'b001111);
      step();
      bus.mem_req = 1'b1;
      #1 check("mx_t1", 64'(bus.ctrl_stall), 64'b011111);
      step();
      #1 check("mx_t2", 64'(bus.ctrl_stall), 64'b011111);
      step();
      #1 check("mx_t3", 64'(bus.ctrl_stall), 64'b011111);
      step();
      bus.mem_ack = 1'b1;
      #1 check("mx_t4", 64'(bus.ctrl_stall), 64'b001111);
      step();
      bus.mem_req = 1'b0;
      bus.mem_ack = 1'b0;
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (bus.ex_mc_done) begin
            lat = 5 + k;
            break;
         end
         step();
      end
      check("mx_done_latency", 64'(lat), 64'd7);
      bus.ex_mc_start = 1'b0;

      // Watchdog: ack never comes
      step();
      bus.mem_req = 1'b1;
      n = 0;
      for (int k = 0; k < 300; k++) begin
         #1;
         if (bus.mem_err)
            break;
         if (bus.ctrl_stall == 6'b011111)
            n++;
         step();
      end
      check("wd_stall_cycles", 64'(n), 64'd255);
      check("wd_err_pulse", 64'(bus.mem_err), 64'd1);
      check("wd_release", 64'(bus.ctrl_stall), 64'd0);
      step();
      bus.mem_req = 1'b0;
      #1 check("wd_err_one_cycle", 64'(bus.mem_err), 64'd0);

      // Branch flush, then suppressed under an EX stall
      step();
      bus.id_branch_flush = 1'b1;
      #1 check("flush_plain", 64'(bus.ctrl_flush), 64'd1);
      step();
      bus.ex_mc_start  = 1'b1;
      bus.ex_mc_cycles = 5'd2;
      #1 check("flush_suppressed", 64'(bus.ctrl_flush), 64'd0);
      check("flush_ex_vec", 64'(bus.ctrl_stall), 64'b001111);
      lat = -1;
      for (int k = 0; k < 20; k++) begin
         #1;
         if (bus.ex_mc_done) begin
            lat = k;
            break;
         end
         step();
      end
      check("flush_op_latency", 64'(lat), 64'd2);
      bus.ex_mc_start     = 1'b0;
      bus.id_branch_flush = 1'b0;

`ifdef CTRL_PERF_EN
      step();
      #1;
      check("perf_mem_total", 64'(perf_mem_stall), 64'd258);
      check("perf_ex_total",  64'(perf_ex_stall),  64'd10);
      check("perf_id_total",  64'(perf_id_stall),  64'd1);
`endif

      // Reset while BUSY with cnt=2
      step();
      bus.ex_mc_start  = 1'b1;
      bus.ex_mc_cycles = 5'd4;
      step();
      step();
      #1;
      rst             = 1'b0;
      bus.ex_mc_start = 1'b0;
      #1 check("rst_async_outputs", {58'd0, bus.ctrl_stall, bus.ctrl_flush, bus.ex_mc_done, bus.mem_err}, 64'd0);
`ifdef CTRL_PERF_EN
      check("rst_perf_clear", 64'(perf_ex_stall), 64'd0);
`endif
      step();
      step();
      rst = 1'b1;
      n = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         #1;
         if (bus.ex_mc_done)
            n++;
      end
      check("rst_no_done", 64'(n), 64'd0);
      check("rst_idle_vec", 64'(bus.ctrl_stall), 64'd0);

      step();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
